// File: rtl/lut_decoder_scoreboard_if.sv
// Handshake and result bus for the LUT decoder scoreboard.
// The master drives run control and checker results; the slave returns
// FSM status, counters, first-error capture and per-lane stickies.
interface lut_decoder_scoreboard_if #(
  parameter int unsigned WCNT = 32
) ();
  logic            start;
  logic            stop;
  logic            chk_valid;
  logic [3:0]      err_vec;
  logic [3:0]      war_vec;

  logic [1:0]      state;
  logic            busy;
  logic            done;
  logic            abort;
  logic [WCNT-1:0] sample_cnt;
  logic [WCNT-1:0] pass_cnt;
  logic [WCNT-1:0] war_cnt;
  logic [WCNT-1:0] err_cnt;
  logic            first_err_vld;
  logic [WCNT-1:0] first_err_idx;
  logic [3:0]      first_err_vec;
  logic [3:0]      err_sticky;
  logic [3:0]      war_sticky;

  modport master (
    output start, stop, chk_valid, err_vec, war_vec,
    input  state, busy, done, abort, sample_cnt, pass_cnt, war_cnt, err_cnt,
           first_err_vld, first_err_idx, first_err_vec, err_sticky, war_sticky
  );

  modport slave (
    input  start, stop, chk_valid, err_vec, war_vec,
    output state, busy, done, abort, sample_cnt, pass_cnt, war_cnt, err_cnt,
           first_err_vld, first_err_idx, first_err_vec, err_sticky, war_sticky
  );
endinterface

// File: rtl/lut_decoder_scoreboard.sv
// Scoreboard for a 4-lane LUT decoder checker: classifies each checker
// result as error / warning / pass, keeps saturating counters, captures the
// first error and per-lane stickies, and aborts after MAX_ERR errors.
// The bus interface must be instantiated with the same WCNT as this module.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | counting samples
// DONE  | run ended by stop, results held
// ABORT | run ended by reaching MAX_ERR errors, results held
module lut_decoder_scoreboard #(
  parameter int unsigned WCNT    = 32,
  parameter int unsigned MAX_ERR = 16
) (
  input  logic                      clk,
  input  logic                      srst,
  lut_decoder_scoreboard_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DONE  = 2'b10,
    ABORT = 2'b11
  } state_e;

  // Extra bit so a MAX_ERR above the counter range can never match.
  localparam logic [WCNT:0] MAX_ERR_W = (WCNT+1)'(MAX_ERR);

  state_e          state_q, state_d;
  logic [WCNT-1:0] sample_cnt_q, sample_cnt_d;
  logic [WCNT-1:0] pass_cnt_q, pass_cnt_d;
  logic [WCNT-1:0] war_cnt_q, war_cnt_d;
  logic [WCNT-1:0] err_cnt_q, err_cnt_d;
  logic            first_err_vld_q, first_err_vld_d;
  logic [WCNT-1:0] first_err_idx_q, first_err_idx_d;
  logic [3:0]      first_err_vec_q, first_err_vec_d;
  logic [3:0]      err_sticky_q, err_sticky_d;
  logic [3:0]      war_sticky_q, war_sticky_d;

  logic            sample;
  logic            is_err;
  logic            is_war;
  logic            abort_hit;

  function automatic logic [WCNT-1:0] sat_inc(input logic [WCNT-1:0] v);
    return (&v) ? v : v + WCNT'(1);
  endfunction

  // Sample classification, counter/capture updates and next-state selection.
  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    pass_cnt_d      = pass_cnt_q;
    war_cnt_d       = war_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vec_d = first_err_vec_q;
    err_sticky_d    = err_sticky_q;
    war_sticky_d    = war_sticky_q;

    sample    = (state_q == RUN) && bus.chk_valid;
    is_err    = |bus.err_vec;
    is_war    = !is_err && (|bus.war_vec);
    // A saturated err_cnt does not advance, so it cannot re-trigger abort.
    abort_hit = (MAX_ERR != 0) && sample && is_err && !(&err_cnt_q) &&
                (({1'b0, err_cnt_q} + (WCNT+1)'(1)) == MAX_ERR_W);

    if (state_q != RUN) begin
      if (bus.start) begin
        state_d         = RUN;
        sample_cnt_d    = '0;
        pass_cnt_d      = '0;
        war_cnt_d       = '0;
        err_cnt_d       = '0;
        first_err_vld_d = 1'b0;
        first_err_idx_d = '0;
        first_err_vec_d = '0;
        err_sticky_d    = '0;
        war_sticky_d    = '0;
      end
    end else begin
      if (sample) begin
        sample_cnt_d = sat_inc(sample_cnt_q);
        err_sticky_d = err_sticky_q | bus.err_vec;
        war_sticky_d = war_sticky_q | bus.war_vec;
        if (is_err) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (!first_err_vld_q) begin
            first_err_vld_d = 1'b1;
            first_err_idx_d = sample_cnt_q;
            first_err_vec_d = bus.err_vec;
          end
        end else if (is_war) begin
          war_cnt_d = sat_inc(war_cnt_q);
        end else begin
          pass_cnt_d = sat_inc(pass_cnt_q);
        end
      end
      if (abort_hit) begin
        state_d = ABORT;
      end else if (bus.stop) begin
        state_d = DONE;
      end
    end
  end

  // State and result registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q         <= IDLE;
      sample_cnt_q    <= '0;
      pass_cnt_q      <= '0;
      war_cnt_q       <= '0;
      err_cnt_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
      first_err_vec_q <= '0;
      err_sticky_q    <= '0;
      war_sticky_q    <= '0;
    end else begin
      state_q         <= state_d;
      sample_cnt_q    <= sample_cnt_d;
      pass_cnt_q      <= pass_cnt_d;
      war_cnt_q       <= war_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vec_q <= first_err_vec_d;
      err_sticky_q    <= err_sticky_d;
      war_sticky_q    <= war_sticky_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.abort         = (state_q == ABORT);
  assign bus.sample_cnt    = sample_cnt_q;
  assign bus.pass_cnt      = pass_cnt_q;
  assign bus.war_cnt       = war_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vld = first_err_vld_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.err_sticky    = err_sticky_q;
  assign bus.war_sticky    = war_sticky_q;

endmodule

// File: tb/tb_lut_decoder_scoreboard.sv
// Directed bench: dut0 uses default parameters, dut1 uses WCNT=2, MAX_ERR=3
// for the abort and saturation scenarios.
module tb_lut_decoder_scoreboard;

  logic clk = 1'b0;
  logic srst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lut_decoder_scoreboard_if #(.WCNT(32)) bus0 ();
  lut_decoder_scoreboard_if #(.WCNT(2))  bus1 ();

  lut_decoder_scoreboard #(.WCNT(32), .MAX_ERR(16)) dut0 (
    .clk(clk), .srst(srst), .bus(bus0.slave)
  );
  lut_decoder_scoreboard #(.WCNT(2), .MAX_ERR(3)) dut1 (
    .clk(clk), .srst(srst), .bus(bus1.slave)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic samp0(input logic [3:0] e, input logic [3:0] w, input logic stp);
    bus0.chk_valid = 1'b1; bus0.err_vec = e; bus0.war_vec = w; bus0.stop = stp;
    cycle();
    bus0.chk_valid = 1'b0; bus0.err_vec = '0; bus0.war_vec = '0; bus0.stop = 1'b0;
  endtask

  task automatic samp1(input logic [3:0] e, input logic [3:0] w, input logic stp);
    bus1.chk_valid = 1'b1; bus1.err_vec = e; bus1.war_vec = w; bus1.stop = stp;
    cycle();
    bus1.chk_valid = 1'b0; bus1.err_vec = '0; bus1.war_vec = '0; bus1.stop = 1'b0;
  endtask

  task automatic start0();
    bus0.start = 1'b1; cycle(); bus0.start = 1'b0;
  endtask

  task automatic start1();
    bus1.start = 1'b1; cycle(); bus1.start = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    bus0.start = 1'b1; bus0.chk_valid = 1'b1; bus0.err_vec = 4'hF;
    cycle(); cycle();
    bus0.start = 1'b0; bus0.chk_valid = 1'b0; bus0.err_vec = '0;
    total++; if (bus0.state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus0.state); end
    total++; if ({bus0.busy, bus0.done, bus0.abort} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus0.busy, bus0.done, bus0.abort}); end
    total++; if (bus0.sample_cnt !== 32'd0 || bus0.err_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus0.sample_cnt, bus0.err_cnt); end
    total++; if (bus1.state !== 2'b00) begin bad++; $display("FAIL reset_state1 got=%0d exp=0", bus1.state); end
    srst = 1'b0;
    // Idle must ignore samples and stop.
    samp0(4'h1, 4'h0, 1'b1);
    cycle();
    total++; if (bus0.state !== 2'b00 || bus0.sample_cnt !== 32'd0 || bus0.err_sticky !== 4'h0) begin bad++; $display("FAIL idle_hold got state=%0d cnt=%0d sticky=%h exp=0/0/0", bus0.state, bus0.sample_cnt, bus0.err_sticky); end
  endtask

  task automatic test_pass_run();
    start0();
    total++; if (bus0.state !== 2'b01 || bus0.busy !== 1'b1) begin bad++; $display("FAIL start_run got state=%0d busy=%b exp=1/1", bus0.state, bus0.busy); end
    for (int i = 0; i < 5; i++) samp0(4'h0, 4'h0, 1'b0);
    bus0.stop = 1'b1; cycle(); bus0.stop = 1'b0;
    total++; if (bus0.sample_cnt !== 32'd5 || bus0.pass_cnt !== 32'd5) begin bad++; $display("FAIL pass_cnts got=%0d/%0d exp=5/5", bus0.sample_cnt, bus0.pass_cnt); end
    total++; if (bus0.done !== 1'b1 || bus0.state !== 2'b10 || bus0.first_err_vld !== 1'b0) begin bad++; $display("FAIL pass_done got done=%b state=%0d fev=%b exp=1/2/0", bus0.done, bus0.state, bus0.first_err_vld); end
  endtask

  task automatic test_mixed();
    start0();
    total++; if (bus0.sample_cnt !== 32'd0 || bus0.pass_cnt !== 32'd0) begin bad++; $display("FAIL restart_clear got=%0d/%0d exp=0/0", bus0.sample_cnt, bus0.pass_cnt); end
    samp0(4'h0, 4'h2, 1'b0);
    total++; if (bus0.war_cnt !== 32'd1 || bus0.sample_cnt !== 32'd1) begin bad++; $display("FAIL latency got war=%0d smp=%0d exp=1/1", bus0.war_cnt, bus0.sample_cnt); end
    samp0(4'h0, 4'h0, 1'b0);
    samp0(4'h4, 4'h0, 1'b0);
    samp0(4'h1, 4'h0, 1'b0);
    total++; if (bus0.err_cnt !== 32'd2 || bus0.war_cnt !== 32'd1 || bus0.pass_cnt !== 32'd1) begin bad++; $display("FAIL mixed_cnts got e=%0d w=%0d p=%0d exp=2/1/1", bus0.err_cnt, bus0.war_cnt, bus0.pass_cnt); end
    total++; if (bus0.first_err_vld !== 1'b1 || bus0.first_err_idx !== 32'd2 || bus0.first_err_vec !== 4'b0100) begin bad++; $display("FAIL first_err got v=%b idx=%0d vec=%b exp=1/2/0100", bus0.first_err_vld, bus0.first_err_idx, bus0.first_err_vec); end
    total++; if (bus0.err_sticky !== 4'b0101 || bus0.war_sticky !== 4'b0010) begin bad++; $display("FAIL stickies got e=%b w=%b exp=0101/0010", bus0.err_sticky, bus0.war_sticky); end
    // start in RUN is ignored; error with warning counts as error only.
    bus0.start = 1'b1; samp0(4'h8, 4'h1, 1'b0); bus0.start = 1'b0;
    total++; if (bus0.sample_cnt !== 32'd5 || bus0.err_cnt !== 32'd3 || bus0.war_cnt !== 32'd1 || bus0.war_sticky !== 4'b0011) begin bad++; $display("FAIL start_in_run got smp=%0d e=%0d w=%0d ws=%b exp=5/3/1/0011", bus0.sample_cnt, bus0.err_cnt, bus0.war_cnt, bus0.war_sticky); end
    total++; if (bus0.first_err_idx !== 32'd2 || bus0.first_err_vec !== 4'b0100) begin bad++; $display("FAIL first_err_hold got idx=%0d vec=%b exp=2/0100", bus0.first_err_idx, bus0.first_err_vec); end
    // Sample in the same cycle as stop is counted.
    samp0(4'h0, 4'h0, 1'b1);
    total++; if (bus0.state !== 2'b10 || bus0.pass_cnt !== 32'd2 || bus0.sample_cnt !== 32'd6) begin bad++; $display("FAIL stop_sample got st=%0d p=%0d smp=%0d exp=2/2/6", bus0.state, bus0.pass_cnt, bus0.sample_cnt); end
    // DONE holds.
    samp0(4'h2, 4'h0, 1'b1);
    total++; if (bus0.err_cnt !== 32'd3 || bus0.sample_cnt !== 32'd6 || bus0.err_sticky !== 4'b1101) begin bad++; $display("FAIL done_hold got e=%0d smp=%0d es=%b exp=3/6/1101", bus0.err_cnt, bus0.sample_cnt, bus0.err_sticky); end
  endtask

  task automatic test_restart_from_done();
    start0();
    samp0(4'h1, 4'h0, 1'b0);
    samp0(4'h2, 4'h0, 1'b1);
    total++; if (bus0.state !== 2'b10 || bus0.err_cnt !== 32'd2) begin bad++; $display("FAIL pre_restart got st=%0d e=%0d exp=2/2", bus0.state, bus0.err_cnt); end
    start0();
    total++; if (bus0.state !== 2'b01 || bus0.err_cnt !== 32'd0 || bus0.first_err_vld !== 1'b0 || bus0.err_sticky !== 4'h0 || bus0.first_err_idx !== 32'd0) begin bad++; $display("FAIL restart_done got st=%0d e=%0d fev=%b es=%b idx=%0d exp=1/0/0/0/0", bus0.state, bus0.err_cnt, bus0.first_err_vld, bus0.err_sticky, bus0.first_err_idx); end
  endtask

  task automatic test_abort();
    start1();
    samp1(4'h1, 4'h0, 1'b0);
    samp1(4'h2, 4'h0, 1'b0);
    total++; if (bus1.state !== 2'b01 || bus1.err_cnt !== 2'd2) begin bad++; $display("FAIL pre_abort got st=%0d e=%0d exp=1/2", bus1.state, bus1.err_cnt); end
    samp1(4'h4, 4'h0, 1'b1);
    total++; if (bus1.state !== 2'b11 || bus1.abort !== 1'b1 || bus1.done !== 1'b0 || bus1.err_cnt !== 2'd3) begin bad++; $display("FAIL abort_wins got st=%0d ab=%b dn=%b e=%0d exp=3/1/0/3", bus1.state, bus1.abort, bus1.done, bus1.err_cnt); end
    samp1(4'h0, 4'h0, 1'b0);
    samp1(4'h8, 4'h0, 1'b0);
    total++; if (bus1.sample_cnt !== 2'd3 || bus1.pass_cnt !== 2'd0 || bus1.err_cnt !== 2'd3 || bus1.state !== 2'b11) begin bad++; $display("FAIL abort_hold got smp=%0d p=%0d e=%0d st=%0d exp=3/0/3/3", bus1.sample_cnt, bus1.pass_cnt, bus1.err_cnt, bus1.state); end
  endtask

  task automatic test_saturate();
    start1();
    for (int i = 0; i < 5; i++) samp1(4'h0, 4'h0, 1'b0);
    total++; if (bus1.pass_cnt !== 2'd3 || bus1.sample_cnt !== 2'd3 || bus1.state !== 2'b01) begin bad++; $display("FAIL saturate got p=%0d smp=%0d st=%0d exp=3/3/1", bus1.pass_cnt, bus1.sample_cnt, bus1.state); end
    samp1(4'h0, 4'h0, 1'b0);
    samp1(4'h3, 4'h0, 1'b0);
    total++; if (bus1.first_err_idx !== 2'd3 || bus1.err_cnt !== 2'd1 || bus1.sample_cnt !== 2'd3) begin bad++; $display("FAIL sat_first_err got idx=%0d e=%0d smp=%0d exp=3/1/3", bus1.first_err_idx, bus1.err_cnt, bus1.sample_cnt); end
    samp1(4'h1, 4'h0, 1'b0);
    samp1(4'h1, 4'h0, 1'b0);
    total++; if (bus1.state !== 2'b11 || bus1.err_cnt !== 2'd3) begin bad++; $display("FAIL sat_abort got st=%0d e=%0d exp=3/3", bus1.state, bus1.err_cnt); end
  endtask

  task automatic test_srst_midrun();
    start0();
    samp0(4'h1, 4'h2, 1'b0);
    srst = 1'b1;
    samp0(4'hF, 4'hF, 1'b0);
    srst = 1'b0;
    total++; if (bus0.state !== 2'b00 || bus0.sample_cnt !== 32'd0 || bus0.err_cnt !== 32'd0 || bus0.busy !== 1'b0) begin bad++; $display("FAIL srst_run got st=%0d smp=%0d e=%0d busy=%b exp=0/0/0/0", bus0.state, bus0.sample_cnt, bus0.err_cnt, bus0.busy); end
    total++; if (bus0.err_sticky !== 4'h0 || bus0.war_sticky !== 4'h0 || bus0.first_err_vld !== 1'b0 || bus0.first_err_vec !== 4'h0) begin bad++; $display("FAIL srst_clear got es=%h ws=%h fev=%b vec=%h exp=0/0/0/0", bus0.err_sticky, bus0.war_sticky, bus0.first_err_vld, bus0.first_err_vec); end
    cycle();
    total++; if (bus0.state !== 2'b00) begin bad++; $display("FAIL srst_stay_idle got st=%0d exp=0", bus0.state); end
    start0();
    samp0(4'h0, 4'h0, 1'b0);
    total++; if (bus0.sample_cnt !== 32'd1 || bus0.pass_cnt !== 32'd1) begin bad++; $display("FAIL post_srst got smp=%0d p=%0d exp=1/1", bus0.sample_cnt, bus0.pass_cnt); end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.stop = 1'b0; bus0.chk_valid = 1'b0; bus0.err_vec = '0; bus0.war_vec = '0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.chk_valid = 1'b0; bus1.err_vec = '0; bus1.war_vec = '0;
    test_reset();
    test_pass_run();
    test_mixed();
    test_restart_from_done();
    test_abort();
    test_saturate();
    test_srst_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_decoder_scoreboard.md
LUT_DECODER_SCOREBOARD -- requirements
Module: lut_decoder_scoreboard

Interface
REQ-001 The block SHALL have parameter WCNT, default 32, which is the width of every counter and index output.
REQ-002 The block SHALL have parameter MAX_ERR, default 16, which is the error-sample count that triggers abort; 0 disables abort.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 srst  input  1  synchronous active-high reset.
REQ-006 start  input  1  start/restart a test run.
REQ-007 stop  input  1  end the test run.
REQ-008 chk_valid  input  1  err_vec/war_vec hold a valid checker result this cycle.
REQ-009 err_vec  input  4  per-lane error flags {err_Y, err_X, err_v, err_u}.
REQ-010 war_vec  input  4  per-lane 1-LSB warning flags {war_Y, war_X, war_v, war_u}.
REQ-011 state  output  2  FSM state encoding.
REQ-012 busy, done, abort  output  1 each  asserted when state is RUN, DONE and ABORT respectively.
REQ-013 sample_cnt, pass_cnt, war_cnt, err_cnt  output  WCNT each  sample counters.
REQ-014 first_err_vld  output  1  a first error has been captured.
REQ-015 first_err_idx  output  WCNT  sample index of the first error sample.
REQ-016 first_err_vec  output  4  err_vec value of the first error sample.
REQ-017 err_sticky, war_sticky  output  4 each  per-lane OR of err_vec/war_vec over the run.

Function
REQ-018 The FSM SHALL use the encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10, ABORT=2'b11; busy, done and abort SHALL be decoded from the state register only.
REQ-019 In IDLE, DONE or ABORT, start=1 SHALL move the FSM to RUN and clear all counters, first_err_* and stickies on the same edge.
REQ-020 In RUN, start SHALL be ignored.
REQ-021 In IDLE, DONE or ABORT, chk_valid SHALL be ignored, stop SHALL be ignored, and all outputs SHALL hold.
REQ-022 Each sample (RUN and chk_valid=1) SHALL be classified as follows: error if |err_vec; warning if no error and |war_vec; otherwise pass.
REQ-023 Each sample SHALL increment sample_cnt by 1 and exactly one of err_cnt, war_cnt or pass_cnt by 1.
REQ-024 Counter updates SHALL be visible the cycle after the sampling edge (1-cycle latency).
REQ-025 Each counter SHALL saturate at all-ones and never wrap; after saturation, sample_cnt can be less than err_cnt+war_cnt+pass_cnt.
REQ-026 On the first error sample of a run, the block SHALL set first_err_vld, load first_err_idx with the pre-increment sample_cnt (0-based), and load first_err_vec with err_vec.
REQ-027 first_err_vld, first_err_idx and first_err_vec SHALL not change again until the next clear.
REQ-028 The block SHALL OR err_vec and war_vec into err_sticky and war_sticky on every sample.
REQ-029 In RUN, if MAX_ERR!=0 and an error sample makes the post-increment err_cnt equal MAX_ERR, the FSM SHALL move to ABORT on that edge.
REQ-030 In RUN, stop=1 SHALL move the FSM to DONE.
REQ-031 A sample presented in the same cycle as stop SHALL be counted.
REQ-032 If stop and the abort condition occur in the same cycle, ABORT SHALL win.
REQ-033 A saturated err_cnt SHALL not re-trigger abort, and the FSM SHALL not transition because of it.

Reset
REQ-034 srst=1 SHALL, on the next posedge clk, force state to IDLE and set every output counter, index, vector, sticky and flag to 0.
REQ-035 srst SHALL have priority over start, stop and chk_valid.
REQ-036 An srst asserted mid-run SHALL discard any sample presented in that cycle.
REQ-037 After srst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-038 Scenario: start, then 5 samples with err_vec=0 and war_vec=0, then stop -> sample_cnt=5, pass_cnt=5, done=1, first_err_vld=0.
REQ-039 Scenario: start, then samples with err_vec = 0, 0, 4'b0100, 4'b0001, and war_vec=4'b0010 on sample 0 -> err_cnt=2, war_cnt=1, pass_cnt=1, first_err_idx=2, first_err_vec=4'b0100, err_sticky=4'b0101, war_sticky=4'b0010.
REQ-040 Scenario: MAX_ERR=3, 3 consecutive error samples with stop asserted on the 3rd -> state=ABORT, err_cnt=3, and any further chk_valid leaves the counts unchanged.
REQ-041 Scenario: WCNT=2, 5 pass samples -> pass_cnt=3 and sample_cnt=3 (saturated), with no wrap.
REQ-042 Scenario: srst asserted in RUN with chk_valid=1 and err_vec=4'hF -> next cycle state=IDLE and all outputs 0; a subsequent start with one pass sample -> sample_cnt=1.
REQ-043 Scenario: start asserted in DONE after a run with err_cnt=2 -> state=RUN and err_cnt=0, with first_err_vld=0 the next cycle.
